// File: rtl/out_port_hex_display.sv
// Output-port consumer: converts each 32-bit write to six BCD digits one bit per clock
// (shift-add-3) and drives six active-low seven-segment displays, with a one-deep pending buffer.
module out_port_hex_display #(
  parameter logic BLANK_LEAD = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic [23:0] bcd_out,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] UPDATE  = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  logic [1:0]       state_q, state_d;
  logic [43:0]      shift_q, shift_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic             busy_q, busy_d;
  logic [23:0]      bcd_q, bcd_d;
  logic [5:0][6:0]  hex_q, hex_d;
  logic             lead;
  logic [3:0]       dig;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // BCD field lives in [43:20], binary operand in [19:0].
  function automatic logic [43:0] dabble(input logic [43:0] s);
    logic [43:0] t;
    t = s;
    for (int unsigned k = 0; k < 6; k++) begin
      if (t[20 + 4*k +: 4] >= 4'd5) t[20 + 4*k +: 4] = t[20 + 4*k +: 4] + 4'd3;
    end
    return {t[42:0], 1'b0};
  endfunction

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    busy_d   = busy_q;
    bcd_d    = bcd_q;
    hex_d    = hex_q;
    lead     = BLANK_LEAD;
    dig      = '0;

    case (state_q)
      IDLE: begin
        if (wr_en) begin
          ovf_d   = wr_data > 32'd999999;
          shift_d = {24'b0, wr_data[19:0]};
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        shift_d = dabble(shift_q);
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'd19) state_d = UPDATE;
        if (wr_en) begin
          pend_d   = wr_data;
          pend_v_d = 1'b1;
        end
      end
      UPDATE: begin
        if (ovf_q) begin
          bcd_d = '1;
          hex_d = {6{SEG_DASH}};
        end else begin
          bcd_d = shift_q[43:20];
          for (int unsigned i = 6; i > 0; i--) begin
            dig = shift_q[20 + 4*(i-1) +: 4];
            if (lead && dig == 4'd0 && i > 1) begin
              hex_d[i-1] = SEG_BLANK;
            end else begin
              hex_d[i-1] = seg7(dig);
              lead       = 1'b0;
            end
          end
        end
        // Pending value (if any) is older than a same-edge write, so it converts first.
        if (pend_v_q || wr_en) begin
          ovf_d    = pend_v_q ? (pend_q > 32'd999999) : (wr_data > 32'd999999);
          shift_d  = {24'b0, pend_v_q ? pend_q[19:0] : wr_data[19:0]};
          cnt_d    = '0;
          state_d  = CONVERT;
          pend_d   = wr_data;
          pend_v_d = pend_v_q && wr_en;
          if (!pend_v_q) pend_d = pend_q;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      busy_q   <= 1'b0;
      bcd_q    <= '0;
      hex_q    <= '1;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      busy_q   <= busy_d;
      bcd_q    <= bcd_d;
      hex_q    <= hex_d;
    end
  end

  assign busy    = busy_q;
  assign bcd_out = bcd_q;
  assign hex0    = hex_q[0];
  assign hex1    = hex_q[1];
  assign hex2    = hex_q[2];
  assign hex3    = hex_q[3];
  assign hex4    = hex_q[4];
  assign hex5    = hex_q[5];

endmodule

// File: tb/tb_out_port_hex_display.sv
// Directed bench for out_port_hex_display: conversion latency, blanking, overflow,
// pending-buffer ordering and reset abort, with hand-computed expected values.
module tb_out_port_hex_display;

  localparam logic [6:0] B  = 7'b1111111;
  localparam logic [6:0] D  = 7'b0111111;
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;

  logic        busy, busy_nb;
  logic [23:0] bcd_out, bcd_nb;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic [6:0]  nb0, nb1, nb2, nb3, nb4, nb5;
  logic [41:0] hex_all, hex_nb;

  int n_checks = 0;
  int n_fail   = 0;

  assign hex_all = {hex5, hex4, hex3, hex2, hex1, hex0};
  assign hex_nb  = {nb5, nb4, nb3, nb2, nb1, nb0};

  always #5 clock = ~clock;

  out_port_hex_display dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .busy(busy), .bcd_out(bcd_out),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
  );

  out_port_hex_display #(.BLANK_LEAD(1'b0)) dut_nb (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .busy(busy_nb), .bcd_out(bcd_nb),
    .hex0(nb0), .hex1(nb1), .hex2(nb2), .hex3(nb3), .hex4(nb4), .hex5(nb5)
  );

  // Returns at the falling edge just after the strobe edge E0.
  task automatic do_write(input logic [31:0] v);
    @(negedge clock);
    wr_en   = 1'b1;
    wr_data = v;
    @(negedge clock);
    wr_en = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset;
    wr_en   = 1'b1;
    wr_data = 32'd123;
    wait_cycles(3);
    n_checks++;
    if (hex_all !== {6{B}}) begin
      n_fail++; $display("FAIL reset_hex: got %h expected %h", hex_all, {6{B}});
    end
    n_checks++;
    if (busy !== 1'b0 || bcd_out !== 24'h0) begin
      n_fail++; $display("FAIL reset_busy_bcd: got busy=%b bcd=%h expected busy=0 bcd=000000", busy, bcd_out);
    end
    wr_en = 1'b0;
    reset = 1'b0;
    wait_cycles(3);
    n_checks++;
    if (busy !== 1'b0 || hex_all !== {6{B}}) begin
      n_fail++; $display("FAIL reset_release_idle: got busy=%b hex=%h expected busy=0 blank", busy, hex_all);
    end
  endtask

  task automatic test_convert;
    do_write(32'd123456);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_after_e0: got %b expected 1", busy);
    end
    wait_cycles(20);
    n_checks++;
    if (busy !== 1'b1 || bcd_out !== 24'h0) begin
      n_fail++; $display("FAIL after_e20: got busy=%b bcd=%h expected busy=1 bcd=000000", busy, bcd_out);
    end
    wait_cycles(1);
    n_checks++;
    if (bcd_out !== 24'h123456 || busy !== 1'b0) begin
      n_fail++; $display("FAIL convert_123456_bcd: got bcd=%h busy=%b expected 123456 busy=0", bcd_out, busy);
    end
    n_checks++;
    if (hex_all !== {S1, S2, S3, S4, S5, S6}) begin
      n_fail++; $display("FAIL convert_123456_hex: got %h expected %h", hex_all, {S1, S2, S3, S4, S5, S6});
    end
  endtask

  task automatic test_blanking;
    do_write(32'd42);
    wait_cycles(21);
    n_checks++;
    if (hex_all !== {B, B, B, B, S4, S2} || bcd_out !== 24'h000042) begin
      n_fail++; $display("FAIL blank_42: got hex=%h bcd=%h expected hex=%h bcd=000042", hex_all, bcd_out, {B, B, B, B, S4, S2});
    end
    n_checks++;
    if (hex_nb !== {S0, S0, S0, S0, S4, S2} || bcd_nb !== 24'h000042) begin
      n_fail++; $display("FAIL noblank_42: got hex=%h bcd=%h expected hex=%h bcd=000042", hex_nb, bcd_nb, {S0, S0, S0, S0, S4, S2});
    end
    do_write(32'd0);
    wait_cycles(21);
    n_checks++;
    if (hex_all !== {B, B, B, B, B, S0} || bcd_out !== 24'h0) begin
      n_fail++; $display("FAIL blank_zero: got hex=%h bcd=%h expected hex=%h bcd=000000", hex_all, bcd_out, {B, B, B, B, B, S0});
    end
  endtask

  task automatic test_overflow;
    do_write(32'd1000000);
    wait_cycles(20);
    n_checks++;
    if (busy !== 1'b1 || hex_all !== {B, B, B, B, B, S0}) begin
      n_fail++; $display("FAIL ovf_latency_e20: got busy=%b hex=%h expected busy=1 previous display", busy, hex_all);
    end
    wait_cycles(1);
    n_checks++;
    if (hex_all !== {6{D}} || bcd_out !== 24'hFFFFFF) begin
      n_fail++; $display("FAIL ovf_1000000: got hex=%h bcd=%h expected hex=%h bcd=ffffff", hex_all, bcd_out, {6{D}});
    end
    do_write(32'd999999);
    wait_cycles(21);
    n_checks++;
    if (hex_all !== {6{S9}} || bcd_out !== 24'h999999) begin
      n_fail++; $display("FAIL max_999999: got hex=%h bcd=%h expected hex=%h bcd=999999", hex_all, bcd_out, {6{S9}});
    end
    do_write(32'hFFFF_FFFF);
    wait_cycles(21);
    n_checks++;
    if (hex_all !== {6{D}} || bcd_out !== 24'hFFFFFF || busy !== 1'b0) begin
      n_fail++; $display("FAIL ovf_ffffffff: got hex=%h bcd=%h busy=%b expected hex=%h bcd=ffffff busy=0", hex_all, bcd_out, busy, {6{D}});
    end
  endtask

  task automatic test_back_to_back;
    logic seen_bad;
    seen_bad = 1'b0;
    do_write(32'd111111);      // E0
    wait_cycles(4);            // after E4
    wr_en   = 1'b1;
    wr_data = 32'd999999;      // sampled at E5
    @(negedge clock);
    wr_data = 32'd7;           // sampled at E6
    @(negedge clock);
    wr_en = 1'b0;              // now after E6
    wait_cycles(15);           // after E21
    n_checks++;
    if (bcd_out !== 24'h111111 || hex_all !== {6{S1}} || busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_first: got bcd=%h hex=%h busy=%b expected bcd=111111 busy=1", bcd_out, hex_all, busy);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bcd_out === 24'h999999) seen_bad = 1'b1;
    end
    n_checks++;
    if (seen_bad !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_overwritten: got seen_999999=%b busy=%b expected 0 and 1", seen_bad, busy);
    end
    @(negedge clock);          // after E42
    n_checks++;
    if (bcd_out !== 24'h000007 || hex_all !== {B, B, B, B, B, S7} || busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second: got bcd=%h hex=%h busy=%b expected bcd=000007 hex=%h busy=0", bcd_out, hex_all, busy, {B, B, B, B, B, S7});
    end
  endtask

  task automatic test_reset_abort;
    do_write(32'd555555);
    wait_cycles(9);
    reset = 1'b1;
    #1;
    n_checks++;
    if (hex_all !== {6{B}} || busy !== 1'b0 || bcd_out !== 24'h0) begin
      n_fail++; $display("FAIL abort_reset: got hex=%h busy=%b bcd=%h expected blank busy=0 bcd=000000", hex_all, busy, bcd_out);
    end
    @(negedge clock);
    reset = 1'b0;
    wait_cycles(25);
    n_checks++;
    if (hex_all !== {6{B}} || bcd_out !== 24'h0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_no_partial: got hex=%h bcd=%h busy=%b expected blank", hex_all, bcd_out, busy);
    end
    do_write(32'd8);
    wait_cycles(21);
    n_checks++;
    if (hex_all !== {B, B, B, B, B, S8} || bcd_out !== 24'h000008 || busy !== 1'b0) begin
      n_fail++; $display("FAIL after_abort_8: got hex=%h bcd=%h busy=%b expected hex=%h bcd=000008", hex_all, bcd_out, busy, {B, B, B, B, B, S8});
    end
  endtask

  initial begin
    test_reset;
    test_convert;
    test_blanking;
    test_overflow;
    test_back_to_back;
    test_reset_abort;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
